// File: rtl/checksum_pkg.sv
// checksum_pkg: shared constants, FSM states and the one's-complement add for the frame checker
package checksum_pkg;
  localparam int FRAME_BITS = 72;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] CS_GOOD = 8'hFF;
  typedef enum logic [2:0] {IDLE, RECV, CHECK, DONE, ABORT} state_e;
  function automatic logic [BYTE_W-1:0] ones_add(input logic [BYTE_W-1:0] a, input logic [BYTE_W-1:0] b);
    logic [BYTE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BYTE_W-1:0] + {{(BYTE_W-1){1'b0}}, s[BYTE_W]};
  endfunction
endpackage

// File: rtl/checksum_acc.sv
// checksum_acc: LSB-first byte deserializer feeding an end-around-carry byte accumulator
module checksum_acc
  import checksum_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              data_i,
  output logic [3:0]        byte_cnt_o,
  output logic [BYTE_W-1:0] sum_o
);
  logic [BYTE_W-1:0] sh_q, sh_d, sum_q, sum_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] byte_q, byte_d;
  logic byte_end;
  assign byte_end = en_i && bit_q == 3'd7;
  always_comb begin
    sh_d = en_i ? {data_i, sh_q[BYTE_W-1:1]} : sh_q;
    bit_d = clr_i ? 3'd0 : en_i ? bit_q + 3'd1 : bit_q;
    // the completed byte is taken from sh_d so it lands on the same edge as its last bit
    sum_d = clr_i ? '0 : byte_end ? ones_add(sum_q, sh_d) : sum_q;
    byte_d = clr_i ? 4'd0 : byte_end ? byte_q + 4'd1 : byte_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sh_q <= '0;
      bit_q <= '0;
      sum_q <= '0;
      byte_q <= '0;
    end else begin
      sh_q <= sh_d;
      bit_q <= bit_d;
      sum_q <= sum_d;
      byte_q <= byte_d;
    end
  end
  assign byte_cnt_o = byte_q;
  assign sum_o = sum_q;
endmodule

// File: rtl/checksum_frame_ctrl.sv
// checksum_frame_ctrl: slices a serial bitstream into 72-bit frames and gates the load on checksum verdicts
module checksum_frame_ctrl
  import checksum_pkg::*;
#(
  parameter int FRAMES  = 16,
  parameter int MAX_ERR = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  output logic             bit_ready_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             frame_ok_o,
  output logic [CNT_W-1:0] frame_idx_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             abort_o
);
  state_e state_q, state_d;
  logic [6:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d, err_q, err_d, err_inc;
  logic accept, start_ok, acc_clr, sum_good;
  logic [3:0] byte_cnt;
  logic [BYTE_W-1:0] sum;
  assign accept = bit_valid_i && state_q == RECV;
  assign start_ok = start_i && state_q inside {IDLE, DONE, ABORT};
  assign acc_clr = start_ok || state_q == CHECK;
  assign sum_good = sum == CS_GOOD && byte_cnt == 4'(FRAME_BITS / BYTE_W);
  assign err_inc = err_q + CNT_W'(err_q != '1);
  checksum_acc u_acc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (acc_clr),
    .en_i      (accept),
    .data_i    (bit_i),
    .byte_cnt_o(byte_cnt),
    .sum_o     (sum)
  );
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d = idx_q;
    err_d = err_q;
    if (start_ok) begin
      state_d = RECV;
      bit_cnt_d = '0;
      idx_d = '0;
      err_d = '0;
    end else if (accept) begin
      state_d = bit_cnt_q == 7'(FRAME_BITS - 1) ? CHECK : RECV;
      bit_cnt_d = bit_cnt_q == 7'(FRAME_BITS - 1) ? '0 : bit_cnt_q + 7'd1;
    end else if (state_q == CHECK) begin
      // abort decision must see this frame's error already counted
      err_d = sum_good ? err_q : err_inc;
      state_d = err_d >= CNT_W'(MAX_ERR) ? ABORT : idx_q == CNT_W'(FRAMES - 1) ? DONE : RECV;
      idx_d = state_d == RECV ? idx_q + 1'b1 : idx_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      idx_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end
  assign bit_ready_o = state_q == RECV;
  assign busy_o = state_q == RECV || state_q == CHECK;
  assign frame_done_o = state_q == CHECK;
  assign frame_ok_o = frame_done_o && sum_good;
  assign frame_idx_o = idx_q;
  assign err_cnt_o = err_q;
  assign done_o = state_q == DONE || state_q == ABORT;
  assign pass_o = state_q == DONE && err_q == '0;
  assign abort_o = state_q == ABORT;
endmodule

// File: tb/tb_checksum_frame_ctrl.sv
// tb_checksum_frame_ctrl: scoreboarded bench for single-frame and three-frame configurations
module tb_checksum_frame_ctrl;
  typedef struct packed {logic ok; logic [7:0] idx;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, bit_valid_i = 1'b0, bit_i = 1'b0;
  logic rdy1, busy1, fd1, fok1, done1, pass1, abort1;
  logic rdy3, busy3, fd3, fok3, done3, pass3, abort3;
  logic [7:0] idx1, err1, idx3, err3;
  int total = 0, bad = 0;
  bit en1 = 0, en3 = 0;
  exp_t q1[$], q3[$];
  localparam logic [71:0] GOOD = {8'hCE, 8'h60, 8'hDF, 8'h1E, 8'h2E, 8'hD0, 8'h60, 8'h60, 8'h13};
  localparam logic [71:0] BAD  = {8'hCE, 8'h60, 8'hDF, 8'h1E, 8'h2E, 8'hD0, 8'h60, 8'h60, 8'h12};
  always #5 clk = ~clk;
  checksum_frame_ctrl #(.FRAMES(1), .MAX_ERR(1), .CNT_W(8)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .bit_ready_o(rdy1), .busy_o(busy1), .frame_done_o(fd1), .frame_ok_o(fok1), .frame_idx_o(idx1),
    .err_cnt_o(err1), .done_o(done1), .pass_o(pass1), .abort_o(abort1));
  checksum_frame_ctrl #(.FRAMES(3), .MAX_ERR(2), .CNT_W(8)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .bit_ready_o(rdy3), .busy_o(busy3), .frame_done_o(fd3), .frame_ok_o(fok3), .frame_idx_o(idx3),
    .err_cnt_o(err3), .done_o(done3), .pass_o(pass3), .abort_o(abort3));

  always @(negedge clk) if (en1 && fd1) begin
    exp_t e;
    total++;
    if (q1.size() == 0) begin
      bad++;
      $display("FAIL mon1 unexpected frame_done ok=%0b idx=%0d", fok1, idx1);
    end else begin
      e = q1.pop_front();
      if ({fok1, idx1} !== e) begin
        bad++;
        $display("FAIL mon1 verdict got ok=%0b idx=%0d want ok=%0b idx=%0d", fok1, idx1, e.ok, e.idx);
      end
    end
  end
  always @(negedge clk) if (en3 && fd3) begin
    exp_t e;
    total++;
    if (q3.size() == 0) begin
      bad++;
      $display("FAIL mon3 unexpected frame_done ok=%0b idx=%0d", fok3, idx3);
    end else begin
      e = q3.pop_front();
      if ({fok3, idx3} !== e) begin
        bad++;
        $display("FAIL mon3 verdict got ok=%0b idx=%0d want ok=%0b idx=%0d", fok3, idx3, e.ok, e.idx);
      end
    end
  end

  task automatic do_reset();
    start_i = 0; bit_valid_i = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic do_start();
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask
  task automatic send_bits(input logic [71:0] f, input int lo, input int hi, input bit gaps, input bit sel);
    for (int i = lo; i < hi; i++) begin
      bit acc = 0;
      int guard = 0;
      while (!acc) begin
        bit_valid_i = gaps ? ($urandom_range(1) == 1) : 1'b1;
        bit_i = f[i];
        @(negedge clk);
        acc = bit_valid_i && (sel ? rdy3 : rdy1);
        @(posedge clk); #1;
        guard++;
        if (guard > 200) begin
          $display("FAIL send_bits timeout at bit %0d", i);
          $display("test done: total=%0d bad=%0d", total, bad + 1);
          $fatal(1);
        end
      end
    end
  endtask
  task automatic send_frame(input logic [71:0] f, input int lo, input bit gaps, input bit sel);
    send_bits(f, lo, 72, gaps, sel);
    bit_valid_i = 1; bit_i = 1'b0;
    @(negedge clk);
    total += 2;
    if ((sel ? fd3 : fd1) !== 1'b1) begin
      bad++; $display("FAIL verdict_latency frame_done got %0b want 1", sel ? fd3 : fd1);
    end
    if ((sel ? rdy3 : rdy1) !== 1'b0) begin
      bad++; $display("FAIL check_ready bit_ready got %0b want 0", sel ? rdy3 : rdy1);
    end
    @(posedge clk); #1;
    bit_valid_i = 0;
  endtask
  task automatic check_result(input bit sel, input logic [3:0] want, input logic [7:0] werr, input string name);
    logic [3:0] got;
    logic [7:0] gerr;
    got = sel ? {busy3, done3, pass3, abort3} : {busy1, done1, pass1, abort1};
    gerr = sel ? err3 : err1;
    total += 2;
    if (got !== want) begin
      bad++; $display("FAIL %s busy/done/pass/abort got %b want %b", name, got, want);
    end
    if (gerr !== werr) begin
      bad++; $display("FAIL %s err_cnt got %0d want %0d", name, gerr, werr);
    end
  endtask
  task automatic check_idle(input string name);
    total += 2;
    if ({rdy1, busy1, fd1, fok1, idx1, err1, done1, pass1, abort1} !== 23'd0) begin
      bad++; $display("FAIL %s dut1 outputs got %h want 0", name, {rdy1, busy1, fd1, fok1, idx1, err1, done1, pass1, abort1});
    end
    if ({rdy3, busy3, fd3, fok3, idx3, err3, done3, pass3, abort3} !== 23'd0) begin
      bad++; $display("FAIL %s dut3 outputs got %h want 0", name, {rdy3, busy3, fd3, fok3, idx3, err3, done3, pass3, abort3});
    end
  endtask
  task automatic check_drained(input string name);
    total++;
    if (q1.size() + q3.size() != 0) begin
      bad++; $display("FAIL %s pending verdicts got %0d want 0", name, q1.size() + q3.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    check_idle("reset_asserted");
    do_reset();
    @(negedge clk);
    check_idle("reset_released");
  endtask
  task automatic test_good();
    do_reset(); en1 = 1; en3 = 0;
    q1.push_back('{1'b1, 8'd0});
    do_start();
    send_frame(GOOD, 0, 0, 0);
    @(negedge clk);
    check_result(0, 4'b0110, 8'd0, "good");
    check_drained("good");
  endtask
  task automatic test_bad();
    do_reset(); en1 = 1; en3 = 0;
    q1.push_back('{1'b0, 8'd0});
    do_start();
    send_frame(BAD, 0, 0, 0);
    @(negedge clk);
    check_result(0, 4'b0101, 8'd1, "bad");
    repeat (3) @(negedge clk);
    check_result(0, 4'b0101, 8'd1, "bad_hold");
    check_drained("bad");
  endtask
  task automatic test_back_to_back();
    do_reset(); en1 = 0; en3 = 1;
    q3.push_back('{1'b1, 8'd0});
    q3.push_back('{1'b0, 8'd1});
    q3.push_back('{1'b1, 8'd2});
    do_start();
    send_frame(GOOD, 0, 0, 1);
    send_frame(BAD, 0, 0, 1);
    send_frame(GOOD, 0, 0, 1);
    @(negedge clk);
    check_result(1, 4'b0100, 8'd1, "three_frames");
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    check_result(1, 4'b1000, 8'd0, "restart");
    check_drained("three_frames");
  endtask
  task automatic test_backpressure();
    do_reset(); en1 = 1; en3 = 0;
    q1.push_back('{1'b1, 8'd0});
    do_start();
    send_frame(GOOD, 0, 1, 0);
    @(negedge clk);
    check_result(0, 4'b0110, 8'd0, "backpressure");
    check_drained("backpressure");
  endtask
  task automatic test_reset_mid();
    do_reset(); en1 = 1; en3 = 0;
    do_start();
    send_bits(GOOD, 0, 40, 0, 0);
    #2 rst_n = 0;
    #1 check_idle("reset_mid");
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(negedge clk);
    check_idle("reset_mid_idle");
    @(posedge clk); #1;
    q1.push_back('{1'b1, 8'd0});
    do_start();
    send_frame(GOOD, 0, 0, 0);
    @(negedge clk);
    check_result(0, 4'b0110, 8'd0, "reset_mid_reload");
    check_drained("reset_mid");
  endtask
  task automatic test_start_busy();
    do_reset(); en1 = 1; en3 = 0;
    q1.push_back('{1'b1, 8'd0});
    do_start();
    send_bits(GOOD, 0, 20, 0, 0);
    bit_valid_i = 0;
    do_start();
    @(negedge clk);
    total += 2;
    if (dut1.bit_cnt_q !== 7'd20) begin
      bad++; $display("FAIL start_busy bit_cnt got %0d want 20", dut1.bit_cnt_q);
    end
    if ({busy1, idx1} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL start_busy busy/idx got %0b/%0d want 1/0", busy1, idx1);
    end
    @(posedge clk); #1;
    send_frame(GOOD, 20, 0, 0);
    @(negedge clk);
    check_result(0, 4'b0110, 8'd0, "start_busy");
    check_drained("start_busy");
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
